// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
// Control sequencer for a shift-and-add multiplier. A Run request drives one
// complete N-iteration multiply: clear A/X, then N add/shift pairs (the last
// add becomes a subtract for the two's-complement sign bit of the multiplier).
// After the multiply, the product is held until Run is released.
//
// Parameters
//   N            operand width / number of iterations (2..16)
// Ports
//   Clk          system clock, rising edge
//   Reset        synchronous, active-high reset
//   Run          start-multiply request (level)
//   ClearA_LoadB clear A / load B request (level, honoured only when idle)
//   M            current LSB of the B register
//   Clr_Ld       clear A and X, load B from switches
//   ClrA         clear A and X only
//   Add          load A with A+S
//   Sub          load A with A-S
//   Shift        arithmetic right shift of X:A:B
//   Busy         multiply in progress
//   Done         product held, waiting for Run release
// ---------------------------------------------------------------------------
module mult_sequencer #(
    parameter int N = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClrA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLRA,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           w_last;

    assign w_last = (r_cnt == LAST);

    // State and iteration counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLRA)
                r_cnt <= '0;
            else if (r_state == S_SHIFT && !w_last)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (Run) w_next = S_CLRA;
            S_CLRA:  w_next = S_ADD;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: w_next = w_last ? S_HOLD : S_ADD;
            // Waiting for Run to fall makes one Run level yield one multiply
            S_HOLD:  if (!Run) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; all outputs forced low while Reset is asserted
    always_comb begin
        Clr_Ld = 1'b0;
        ClrA   = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        if (!Reset) begin
            unique case (r_state)
                // Run takes priority over a simultaneous load request
                S_IDLE:  Clr_Ld = ClearA_LoadB & ~Run;
                S_CLRA: begin
                    ClrA = 1'b1;
                    Busy = 1'b1;
                end
                // Final iteration subtracts: the multiplier MSB has negative weight
                S_ADD: begin
                    Add  = M & ~w_last;
                    Sub  = M &  w_last;
                    Busy = 1'b1;
                end
                S_SHIFT: begin
                    Shift = 1'b1;
                    Busy  = 1'b1;
                end
                S_HOLD:  Done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_sequencer
// Self-checking bench for mult_sequencer (N=8). The reference model tracks
// the cycle position within a multiply (0 = idle, 1 = clear, 2..2N+1 =
// add/shift iterations, 2N+2 = hold) and derives the expected outputs from it.
// ---------------------------------------------------------------------------
module tb_mult_sequencer;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clr_Ld, ClrA, Add, Sub, Shift, Busy, Done;

    int checks = 0;
    int errors = 0;
    int pos    = 0;
    logic [6:0] obs, exp_v;

    mult_sequencer #(.N(N)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .ClrA         (ClrA),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    // Expected outputs {Clr_Ld, ClrA, Add, Sub, Shift, Busy, Done}
    function automatic logic [6:0] model_out(int p, logic rst, logic run, logic clab, logic m);
        logic cl, ca, ad, sb, sh, bs, dn;
        int k;
        cl = 0; ca = 0; ad = 0; sb = 0; sh = 0; bs = 0; dn = 0;
        if (!rst) begin
            if (p == 0) begin
                cl = clab & ~run;
            end else if (p == 1) begin
                ca = 1; bs = 1;
            end else if (p <= 2*N+1) begin
                bs = 1;
                if (p % 2 == 0) begin
                    k  = (p - 2) / 2;
                    ad = m && (k <  N-1);
                    sb = m && (k == N-1);
                end else begin
                    sh = 1;
                end
            end else begin
                dn = 1;
            end
        end
        return {cl, ca, ad, sb, sh, bs, dn};
    endfunction

    function automatic int model_next(int p, logic rst, logic run);
        if (rst)              return 0;
        if (p == 0)           return run ? 1 : 0;
        if (p <= 2*N+1)       return p + 1;
        return run ? p : 0;
    endfunction

    // Drive one cycle of inputs, capture DUT and model outputs, advance clock
    task automatic step(input logic rst, input logic run, input logic clab, input logic m);
        Reset = rst; Run = run; ClearA_LoadB = clab; M = m;
        #1;
        obs   = {Clr_Ld, ClrA, Add, Sub, Shift, Busy, Done};
        exp_v = model_out(pos, rst, run, clab, m);
        @(posedge Clk);
        #1;
        pos = model_next(pos, rst, run);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_outputs i=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=%b", obs, 7'b0);
        end
    endtask

    task automatic test_clear_load();
        int n_cl = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, (i < 2), 1'b0);
            n_cl += int'(obs[6]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clear_load i=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        checks++;
        if (n_cl != 2) begin
            errors++;
            $display("FAIL clear_load_count got=%0d exp=2", n_cl);
        end
    endtask

    task automatic test_full_m1();
        int n_add = 0, n_sub = 0, n_sh = 0, first_done = -1;
        for (int i = 0; i < 2*N+5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            n_add += int'(obs[4]); n_sub += int'(obs[3]); n_sh += int'(obs[2]);
            if (obs[0] && first_done < 0) first_done = i;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL full_m1 cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL full_m1_release got=%b exp=%b", obs, exp_v);
        end
        checks++;
        if (n_add != N-1 || n_sub != 1 || n_sh != N || first_done != 2*N+2) begin
            errors++;
            $display("FAIL full_m1_counts add=%0d sub=%0d sh=%0d done@%0d exp %0d/1/%0d/%0d",
                     n_add, n_sub, n_sh, first_done, N-1, N, 2*N+2);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_alt_m();
        int n_add = 0, n_sub = 0, n_sh = 0;
        for (int i = 0; i < 2*N+4; i++) begin
            step(1'b0, 1'b1, 1'b0, logic'((i/2 + 1) % 2));
            n_add += int'(obs[4]); n_sub += int'(obs[3]); n_sh += int'(obs[2]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alt_m cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_add != 3 || n_sub != 1 || n_sh != N) begin
            errors++;
            $display("FAIL alt_m_counts add=%0d sub=%0d sh=%0d exp 3/1/%0d", n_add, n_sub, n_sh, N);
        end
    endtask

    task automatic test_run_and_clear();
        int n_cl = 0;
        for (int i = 0; i < 2*N+3; i++) begin
            step(1'b0, 1'b1, (i == 0) || (i % 3 == 1), logic'($urandom_range(1)));
            n_cl += int'(obs[6]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_and_clear cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_cl != 0) begin
            errors++;
            $display("FAIL run_and_clear_count got=%0d exp=0", n_cl);
        end
    endtask

    task automatic test_reset_mid();
        int n_sh = 0;
        for (int i = 0; i < 11; i++) begin
            step(i == 9, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        // Run was still high after reset: a fresh multiply is already running
        for (int i = 0; i < 2*N+2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            n_sh += int'(obs[2]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_rerun cyc=%0d got=%b exp=%b", i, obs, exp_v);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_sh < N-1) begin
            errors++;
            $display("FAIL reset_mid_shifts got=%0d exp>=%0d", n_sh, N-1);
        end
    endtask

    task automatic test_run_drop();
        int n_sh, n_dn;
        for (int rep = 0; rep < 2; rep++) begin
            n_sh = 0; n_dn = 0;
            for (int i = 0; i < 2*N+6; i++) begin
                step(1'b0, (i < 5), 1'b0, logic'($urandom_range(1)));
                n_sh += int'(obs[2]); n_dn += int'(obs[0]);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL run_drop rep=%0d cyc=%0d got=%b exp=%b", rep, i, obs, exp_v);
                end
            end
            checks++;
            if (n_sh != N || n_dn != 1) begin
                errors++;
                $display("FAIL run_drop_counts rep=%0d sh=%0d done=%0d exp %0d/1", rep, n_sh, n_dn, N);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(59) == 0, $urandom_range(3) != 0,
                 logic'($urandom_range(1)), logic'($urandom_range(1)));
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d pos=%0d got=%b exp=%b", i, pos, obs, exp_v);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_clear_load();
        test_full_m1();
        test_alt_m();
        test_run_and_clear();
        test_reset_mid();
        test_run_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
